// File: rtl/fetch_pc_unit.sv
// Program counter register and single-outstanding instruction fetch sequencer.
// Fetches at pc, buffers the returned word, and advances to pc_next on commit.
module fetch_pc_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_next,
    input  logic             commit,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             fetch_misaligned
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_TRAP
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] instr_reg;
    logic             instr_valid_reg;
    logic             misaligned_reg;
    logic             req_fire;
    logic             next_aligned;

    // The request is gated by rst so it drops in the very cycle reset is applied
    // and rises again in the first cycle after release.
    assign imem_req_valid   = (state_reg == S_REQ) && !rst;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign next_aligned     = (pc_next[1:0] == 2'b00);

    assign imem_addr        = pc_reg;
    assign pc               = pc_reg;
    assign pc_plus4         = pc_reg + WIDTH'(4);
    assign instr            = instr_reg;
    assign instr_valid      = instr_valid_reg;
    assign fetch_misaligned = misaligned_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_REQ;
            pc_reg          <= RESET_PC;
            instr_reg       <= {WIDTH{1'b0}};
            instr_valid_reg <= 1'b0;
            misaligned_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (req_fire) begin
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        instr_reg       <= imem_rsp_data;
                        instr_valid_reg <= 1'b1;
                        state_reg       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (commit) begin
                        instr_valid_reg <= 1'b0;
                        if (next_aligned) begin
                            pc_reg    <= pc_next;
                            state_reg <= S_REQ;
                        end else begin
                            misaligned_reg <= 1'b1;
                            state_reg      <= S_TRAP;
                        end
                    end
                end
                S_TRAP: begin
                    // Terminal until reset; keep the flag asserted.
                    misaligned_reg <= 1'b1;
                end
                default: begin
                    state_reg <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: table of fetch transactions plus
// hand-written misaligned-trap and reset-during-wait sequences.
module tb_fetch_pc_unit;

    localparam int          WIDTH    = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] pc_next;
    logic        commit;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_misaligned;

    fetch_pc_unit #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_next          (pc_next),
        .commit           (commit),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_addr        (imem_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .fetch_misaligned (fetch_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rsp;
        int          ready_dly;
        int          rsp_dly;
        int          hold;
        logic [31:0] next_pc;
    } vec_t;

    int          checks;
    int          errors;
    logic [31:0] model_pc;
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_addr_q[$];
    vec_t        vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_pc();
        logic [31:0] exp_p4;
        exp_p4 = model_pc + 32'd4;
        chk("pc", pc, model_pc);
        chk("pc_plus4", pc_plus4, exp_p4);
    endtask

    // Present a request for ready_dly cycles with ready low, then accept it.
    task automatic do_req(input int ready_dly);
        logic [31:0] exp_addr;
        imem_req_ready = 1'b0;
        for (int i = 0; i < ready_dly; i++) begin
            #1;
            chk("req_valid_stall", {31'b0, imem_req_valid}, 32'd1);
            chk("addr_stall", imem_addr, model_pc);
            step();
        end
        imem_req_ready = 1'b1;
        exp_addr_q.push_back(model_pc);
        #1;
        chk("req_valid_fire", {31'b0, imem_req_valid}, 32'd1);
        if (imem_req_valid && imem_req_ready && exp_addr_q.size() > 0) begin
            exp_addr = exp_addr_q.pop_front();
            chk("fetch_addr", imem_addr, exp_addr);
        end
        step();
        imem_req_ready = 1'b0;
    endtask

    // Wait rsp_dly cycles (with commit asserted, which must be ignored), then respond.
    task automatic do_rsp(input int rsp_dly, input logic [31:0] data);
        for (int i = 0; i < rsp_dly; i++) begin
            commit  = 1'b1;
            pc_next = $urandom;
            #1;
            chk("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
            chk("wait_instr_valid", {31'b0, instr_valid}, 32'd0);
            step();
        end
        commit         = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        exp_instr_q.push_back(data);
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
    endtask

    task automatic do_hold(input int hold, input logic [31:0] next);
        logic [31:0] exp_instr;
        logic [31:0] held_pc;
        #1;
        chk("instr_valid", {31'b0, instr_valid}, 32'd1);
        if (exp_instr_q.size() > 0) exp_instr = exp_instr_q.pop_front();
        else exp_instr = 32'hxxxx_xxxx;
        chk("instr", instr, exp_instr);
        check_pc();
        for (int i = 0; i < hold; i++) begin
            commit         = 1'b0;
            pc_next        = $urandom;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
            step();
            chk("hold_instr_valid", {31'b0, instr_valid}, 32'd1);
            chk("hold_instr", instr, exp_instr);
            chk("hold_req_valid", {31'b0, imem_req_valid}, 32'd0);
            check_pc();
        end
        imem_rsp_valid = 1'b0;
        commit         = 1'b1;
        pc_next        = next;
        step();
        commit = 1'b0;
        held_pc = model_pc;
        if (next[1:0] == 2'b00) begin
            model_pc = next;
            chk("post_commit_instr_valid", {31'b0, instr_valid}, 32'd0);
            chk("next_req_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("next_addr", imem_addr, model_pc);
            check_pc();
        end else begin
            chk("trap_misaligned", {31'b0, fetch_misaligned}, 32'd1);
            chk("trap_pc", pc, held_pc);
            chk("trap_instr_valid", {31'b0, instr_valid}, 32'd0);
            chk("trap_req_valid", {31'b0, imem_req_valid}, 32'd0);
            for (int i = 0; i < 3; i++) begin
                imem_req_ready = 1'b1;
                imem_rsp_valid = 1'b1;
                commit         = 1'b1;
                pc_next        = 32'h0000_0200;
                step();
                chk("trap_stay_req_valid", {31'b0, imem_req_valid}, 32'd0);
                chk("trap_stay_misaligned", {31'b0, fetch_misaligned}, 32'd1);
                chk("trap_stay_pc", pc, held_pc);
            end
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b0;
            commit         = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        rst = 1'b0;
        model_pc = RESET_PC;
        #1;
        chk("rst_pc", pc, RESET_PC);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_misaligned", {31'b0, fetch_misaligned}, 32'd0);
        chk("rst_release_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rst_addr", imem_addr, RESET_PC);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        pc_next        = '0;
        commit         = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        model_pc       = RESET_PC;

        vecs[0] = '{rsp: 32'h0000_0013, ready_dly: 0, rsp_dly: 0, hold: 0, next_pc: 32'h0000_0004};
        vecs[1] = '{rsp: 32'h0010_0093, ready_dly: 5, rsp_dly: 0, hold: 4, next_pc: 32'h0000_0100};
        vecs[2] = '{rsp: 32'h0000_000A, ready_dly: 0, rsp_dly: 3, hold: 0, next_pc: 32'h0000_0100};
        vecs[3] = '{rsp: 32'h0000_000B, ready_dly: 2, rsp_dly: 1, hold: 1, next_pc: 32'hFFFF_FFFC};
        vecs[4] = '{rsp: 32'h0000_000C, ready_dly: 0, rsp_dly: 0, hold: 0, next_pc: 32'h0000_0008};

        apply_reset();

        for (int v = 0; v < 5; v++) begin
            do_req(vecs[v].ready_dly);
            do_rsp(vecs[v].rsp_dly, vecs[v].rsp);
            do_hold(vecs[v].hold, vecs[v].next_pc);
        end

        // Misaligned commit traps until reset.
        do_req(1);
        do_rsp(0, 32'h1234_5678);
        do_hold(2, 32'h0000_0102);
        apply_reset();

        // Reset while a response is pending; the late response must be dropped.
        do_req(0);
        chk("wait_entry_req_valid", {31'b0, imem_req_valid}, 32'd0);
        rst = 1'b1;
        step();
        chk("rst_in_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
        rst            = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        model_pc       = RESET_PC;
        #1;
        chk("late_rsp_req_valid", {31'b0, imem_req_valid}, 32'd1);
        step();
        imem_rsp_valid = 1'b0;
        chk("late_rsp_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("late_rsp_instr", instr, 32'd0);
        chk("late_rsp_req_again", {31'b0, imem_req_valid}, 32'd1);
        chk("late_rsp_addr", imem_addr, RESET_PC);

        // The fetch after the dropped response still completes normally.
        do_req(0);
        do_rsp(0, 32'h0000_0033);
        do_hold(0, 32'h0000_0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
